// File: rtl/stack_if.sv
// stack_if: push/pop handshake and status bundle for the operand stack.
// STACK_ERR_EN adds the sticky err_ovf/err_unf flags.
interface stack_if #(
    parameter int WIDTH = 64
);
    logic push;
    logic pop;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] pop_data;
    logic isEmpty;
    logic isFull;
`ifdef STACK_ERR_EN
    logic err_ovf;
    logic err_unf;
    modport master(output push, pop, push_data, input pop_data, isEmpty, isFull, err_ovf, err_unf);
    modport slave(input push, pop, push_data, output pop_data, isEmpty, isFull, err_ovf, err_unf);
`else
    modport master(output push, pop, push_data, input pop_data, isEmpty, isFull);
    modport slave(input push, pop, push_data, output pop_data, isEmpty, isFull);
`endif
endinterface

// File: rtl/stack.sv
// stack: LIFO operand stack with registered pop result and empty/full flags.
// STACK_ERR_EN adds sticky overflow/underflow flags; rst_n is active-high despite its name.
module stack #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input logic clk,
    input logic rst_n,
    stack_if.slave bus
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] count;
    logic [PTR_W-2:0] tidx;
    logic [PTR_W-2:0] widx;
    logic do_push;
    logic do_pop;
    // A full stack's low count bits are zero, so tidx still wraps to DEPTH-1
    always_comb begin
        tidx = count[PTR_W-2:0] - (PTR_W-1)'(1);
        do_pop = bus.pop && count != '0;
        do_push = bus.push && (count != PTR_W'(DEPTH) || do_pop);
        widx = do_pop ? tidx : count[PTR_W-2:0];
    end
    always_ff @(posedge clk)
        if (do_push) mem[widx] <= bus.push_data;
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            count <= '0;
            bus.pop_data <= '0;
        end else begin
            count <= count + PTR_W'(do_push) - PTR_W'(do_pop);
            if (do_pop) bus.pop_data <= mem[tidx];
        end
    assign bus.isEmpty = count == '0;
    assign bus.isFull = count == PTR_W'(DEPTH);
`ifdef STACK_ERR_EN
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            bus.err_ovf <= 1'b0;
            bus.err_unf <= 1'b0;
        end else begin
            if (bus.push && !bus.pop && count == PTR_W'(DEPTH)) bus.err_ovf <= 1'b1;
            if (bus.pop && count == '0) bus.err_unf <= 1'b1;
        end
`endif
endmodule

// File: tb/tb_stack.sv
// tb_stack: vector table, corner sequences and random traffic checked against a queue model.
module tb_stack;
    localparam int WIDTH = 64;
    localparam int DEPTH = 16;
    typedef struct {
        logic p;
        logic o;
        logic [63:0] d;
        logic [63:0] pd;
        logic e;
        logic f;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [63:0] q[$];
    logic [63:0] m_pd = '0;
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;
    vec_t tbl[12];
    stack_if #(.WIDTH(WIDTH)) bus ();
    stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic drive(input logic p, input logic o, input logic [63:0] d);
        @(negedge clk);
        bus.push = p;
        bus.pop = o;
        bus.push_data = d;
        @(posedge clk);
        if (o) begin
            if (q.size() > 0) begin
                m_pd = q[$];
                q.pop_back();
            end else m_unf = 1'b1;
        end
        if (p) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovf = 1'b1;
        end
        #1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
    endtask
    task automatic check_model(input string tag);
        chk({tag, " pop_data"}, bus.pop_data, m_pd);
        chk({tag, " isEmpty"}, 64'(bus.isEmpty), 64'(q.size() == 0));
        chk({tag, " isFull"}, 64'(bus.isFull), 64'(q.size() == DEPTH));
`ifdef STACK_ERR_EN
        chk({tag, " err_ovf"}, 64'(bus.err_ovf), 64'(m_ovf));
        chk({tag, " err_unf"}, 64'(bus.err_unf), 64'(m_unf));
`endif
    endtask
    initial begin
        logic [63:0] v;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.push_data = '0;
        tbl[0] = '{1'b1, 1'b0, 64'hA5A5A5A5A5A5A5A5, 64'h0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 64'h7B7B7B7B7B7B7B7B, 64'h0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 64'h0, 64'h7B7B7B7B7B7B7B7B, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 64'h9999999999999999, 64'h7B7B7B7B7B7B7B7B, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 64'h0, 64'h9999999999999999, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 64'h0, 64'hA5A5A5A5A5A5A5A5, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 64'h0, 64'hA5A5A5A5A5A5A5A5, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 64'h1, 64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 64'h2, 64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 64'h3, 64'h2, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 64'h0, 64'h3, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 64'h0, 64'h1, 1'b1, 1'b0};
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset pop_data", bus.pop_data, 64'h0);
        chk("reset isEmpty", 64'(bus.isEmpty), 64'h1);
        chk("reset isFull", 64'(bus.isFull), 64'h0);
`ifdef STACK_ERR_EN
        chk("reset err_ovf", 64'(bus.err_ovf), 64'h0);
        chk("reset err_unf", 64'(bus.err_unf), 64'h0);
`endif
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].p, tbl[i].o, tbl[i].d);
            chk($sformatf("vec%0d pop_data", i), bus.pop_data, tbl[i].pd);
            chk($sformatf("vec%0d isEmpty", i), 64'(bus.isEmpty), 64'(tbl[i].e));
            chk($sformatf("vec%0d isFull", i), 64'(bus.isFull), 64'(tbl[i].f));
        end
`ifdef STACK_ERR_EN
        chk("underflow err_unf", 64'(bus.err_unf), 64'h1);
        chk("no overflow err_ovf", 64'(bus.err_ovf), 64'h0);
`endif
        for (int k = 0; k < DEPTH; k++) drive(1'b1, 1'b0, {32'hC0DE0000 + 32'(k), 32'(k)});
        chk("fill isFull", 64'(bus.isFull), 64'h1);
        drive(1'b1, 1'b0, 64'hDEAD);
        chk("overfill isFull", 64'(bus.isFull), 64'h1);
`ifdef STACK_ERR_EN
        chk("overfill err_ovf", 64'(bus.err_ovf), 64'h1);
`endif
        for (int k = DEPTH - 1; k >= 0; k--) begin
            drive(1'b0, 1'b1, 64'h0);
            v = {32'hC0DE0000 + 32'(k), 32'(k)};
            chk($sformatf("drain%0d pop_data", k), bus.pop_data, v);
        end
        chk("drained isEmpty", 64'(bus.isEmpty), 64'h1);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 64'h55 + 64'(k));
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("async pop_data", bus.pop_data, 64'h0);
        chk("async isEmpty", 64'(bus.isEmpty), 64'h1);
        chk("async isFull", 64'(bus.isFull), 64'h0);
        rst_n = 1'b0;
        q.delete();
        m_pd = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        drive(1'b0, 1'b1, 64'h0);
        check_model("post-reset pop");
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 100) % 2 == 1) ? 25 : 75;
            drive($urandom_range(0, 99) < bias, $urandom_range(0, 99) < 50, {$urandom(), $urandom()});
            check_model($sformatf("rand%0d", i));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
